pkt_buf_writer: RTL and testbench

PKT_BUF_WRITER -- requirements
Module: pkt_buf_writer

---
 rtl/pkt_buf_writer_pkg.sv | 37 +++
 rtl/pkt_buf_writer_if.sv | 45 ++++
 rtl/pkt_buf_writer_stats_cnt.sv | 21 ++
 rtl/pkt_buf_writer.sv | 145 ++++++++++++++
 tb/tb_pkt_buf_writer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/pkt_buf_writer_pkg.sv
// Shared types and sizing for the packet-buffer writer: flit/meta types,
// slot geometry and the FSM state encoding.
package pkt_buf_writer_pkg;

    localparam int SLOT_FLITS    = 32;
    localparam int FLIT_IDX_W    = $clog2(SLOT_FLITS);
    localparam int PKT_NUMW      = 8;
    localparam int PKTBUF_AWIDTH = PKT_NUMW + FLIT_IDX_W;
    localparam int FLIT_W        = 512;
    localparam int FLIT_BYTES_W  = 6;   // log2 of 64 bytes per flit
    localparam int CNT_W         = 16;
    localparam int LEN_W         = 16;
    localparam int META_FLITS_W  = 6;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef struct packed {
        logic [PKT_NUMW-1:0]     pkt_id;
        logic [META_FLITS_W-1:0] flits;
        logic [LEN_W-1:0]        len;
        logic                    truncated;
    } pbuf_meta_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        META  = 2'd2
    } wr_state_e;

    // Flits actually stored in a slot: the accepted count clamped to the slot size.
    function automatic logic [META_FLITS_W-1:0] clamp_flits(input logic [CNT_W-1:0] cnt,
                                                            input int slot);
        if (cnt >= CNT_W'(slot)) return META_FLITS_W'(slot);
        else                     return cnt[META_FLITS_W-1:0];
    endfunction

endpackage

// File: rtl/pkt_buf_writer_if.sv
// Bundle of the ingress stream, emptylist pop, buffer write and meta handshake.
// master = the writer block, slave = its surroundings.
interface pkt_buf_writer_if;
    import pkt_buf_writer_pkg::*;

    logic                     in_pkt_sop;
    logic                     in_pkt_eop;
    logic                     in_pkt_valid;
    flit_t                    in_pkt_data;
    logic [5:0]               in_pkt_empty;
    logic                     in_pkt_ready;

    logic [PKT_NUMW-1:0]      emptylist_out_data;
    logic                     emptylist_out_valid;
    logic                     emptylist_out_ready;

    logic [PKTBUF_AWIDTH-1:0] pkt_buffer_address;
    logic                     pkt_buffer_write;
    flit_t                    pkt_buffer_writedata;

    logic                     meta_valid;
    pbuf_meta_t               meta_data;
    logic                     meta_ready;

    modport master (
        input  in_pkt_sop, in_pkt_eop, in_pkt_valid, in_pkt_data, in_pkt_empty,
        output in_pkt_ready,
        input  emptylist_out_data, emptylist_out_valid,
        output emptylist_out_ready,
        output pkt_buffer_address, pkt_buffer_write, pkt_buffer_writedata,
        output meta_valid, meta_data,
        input  meta_ready
    );

    modport slave (
        output in_pkt_sop, in_pkt_eop, in_pkt_valid, in_pkt_data, in_pkt_empty,
        input  in_pkt_ready,
        output emptylist_out_data, emptylist_out_valid,
        input  emptylist_out_ready,
        input  pkt_buffer_address, pkt_buffer_write, pkt_buffer_writedata,
        input  meta_valid, meta_data,
        output meta_ready
    );

endinterface

// File: rtl/pkt_buf_writer_stats_cnt.sv
// 32-bit free-running event counter: counts cycles with valid & ready, wraps.
module stats_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic        i_ready,
    output logic [31:0] o_count
);

    logic [31:0] r_count;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst)                   r_count <= '0;
        else if (i_valid & i_ready) r_count <= r_count + 32'd1;
    end

    assign o_count = r_count;

endmodule

// File: rtl/pkt_buf_writer.sv
// Claims a free pktID, writes one packet's flits into its buffer slot and
// then publishes a meta record describing what was stored.
module pkt_buf_writer #(
    parameter int SLOT_FLITS = pkt_buf_writer_pkg::SLOT_FLITS,
    parameter int FLIT_IDX_W = $clog2(SLOT_FLITS)
) (
    input  logic               clk,
    input  logic               rst,
    pkt_buf_writer_if.master   bus,
    output logic [31:0]        stats_in_pkt,
    output logic [31:0]        stats_trunc_pkt,
    output logic [31:0]        stats_sop_err
);
    import pkt_buf_writer_pkg::*;

    wr_state_e                r_state, w_next;
    logic                     w_in_ready, w_el_ready, w_meta_valid;
    logic                     w_accept, w_pop, w_sop_err, w_take;

    logic [PKT_NUMW-1:0]      r_pkt_id;
    logic [CNT_W-1:0]         r_count;
    logic                     r_trunc;
    logic                     r_sop_seen;
    logic [5:0]               r_empty;

    logic                     r_wr;
    logic [PKTBUF_AWIDTH-1:0] r_addr;
    flit_t                    r_wdata;
    pbuf_meta_t               w_meta;

    // Handshake qualifiers; a leading non-sop flit is swallowed as an error.
    assign w_accept  = bus.in_pkt_valid & w_in_ready;
    assign w_pop     = bus.emptylist_out_valid & w_el_ready;
    assign w_sop_err = w_accept & ~r_sop_seen & ~bus.in_pkt_sop;
    assign w_take    = w_accept & ~w_sop_err;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves a signal unassigned and infers a latch.
    always_comb begin
        w_next       = r_state;
        w_in_ready   = 1'b0;
        w_el_ready   = 1'b0;
        w_meta_valid = 1'b0;
        if (!rst) begin
            unique case (r_state)
                IDLE: begin
                    w_el_ready = 1'b1;
                    if (bus.emptylist_out_valid) w_next = WRITE;
                end
                WRITE: begin
                    w_in_ready = 1'b1;
                    if (w_take && bus.in_pkt_eop) w_next = META;
                end
                META: begin
                    w_meta_valid = 1'b1;
                    if (bus.meta_ready) w_next = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // NOTE: the wide writedata register is reset like the rest because it is
    // a visible port value, not a storage array.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_id   <= '0;
            r_count    <= '0;
            r_trunc    <= 1'b0;
            r_sop_seen <= 1'b0;
            r_empty    <= '0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_wr <= 1'b0;
            if (w_pop) begin
                r_pkt_id   <= bus.emptylist_out_data;
                r_count    <= '0;
                r_trunc    <= 1'b0;
                r_sop_seen <= 1'b0;
                r_empty    <= '0;
            end
            if (w_take) begin
                r_count    <= r_count + CNT_W'(1);
                r_sop_seen <= 1'b1;
                if (bus.in_pkt_eop) r_empty <= bus.in_pkt_empty;
                if (r_count < CNT_W'(SLOT_FLITS)) begin
                    r_wr    <= 1'b1;
                    r_addr  <= {r_pkt_id, r_count[FLIT_IDX_W-1:0]};
                    r_wdata <= bus.in_pkt_data;
                end else begin
                    r_trunc <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_meta.pkt_id    = r_pkt_id;
        w_meta.flits     = clamp_flits(r_count, SLOT_FLITS);
        w_meta.len       = LEN_W'(r_count << FLIT_BYTES_W) - LEN_W'(r_empty);
        w_meta.truncated = r_trunc;
    end

    // Outputs are forced low while rst is high so an abandoned packet never
    // leaks a pending write or meta record.
    assign bus.in_pkt_ready         = w_in_ready;
    assign bus.emptylist_out_ready  = w_el_ready;
    assign bus.meta_valid           = w_meta_valid;
    assign bus.meta_data            = rst ? '0 : w_meta;
    assign bus.pkt_buffer_write     = r_wr & ~rst;
    assign bus.pkt_buffer_address   = rst ? '0 : r_addr;
    assign bus.pkt_buffer_writedata = rst ? '0 : r_wdata;

    stats_cnt u_cnt_in_pkt (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_meta_valid),
        .i_ready (bus.meta_ready),
        .o_count (stats_in_pkt)
    );

    stats_cnt u_cnt_trunc (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_meta_valid & r_trunc),
        .i_ready (bus.meta_ready),
        .o_count (stats_trunc_pkt)
    );

    stats_cnt u_cnt_sop_err (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_sop_err),
        .i_ready (1'b1),
        .o_count (stats_sop_err)
    );

endmodule

// File: tb/tb_pkt_buf_writer.sv
// Directed bench for pkt_buf_writer: slot writes, truncation, sop errors,
// meta back-pressure and mid-packet reset.
module tb_pkt_buf_writer;
    import pkt_buf_writer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] stats_in_pkt, stats_trunc_pkt, stats_sop_err;
    int          total = 0;
    int          bad = 0;
    int          wr_total = 0;

    pkt_buf_writer_if bus ();

    pkt_buf_writer dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .stats_in_pkt    (stats_in_pkt),
        .stats_trunc_pkt (stats_trunc_pkt),
        .stats_sop_err   (stats_sop_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.pkt_buffer_write === 1'b1) wr_total++;

    task automatic check(input string tag, input logic [FLIT_W-1:0] obs,
                         input logic [FLIT_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic flit_t mk_data(input logic [7:0] id, input int i);
        return {16{id, 8'(i), 16'hA5C3}};
    endfunction

    task automatic give_id(input logic [7:0] id);
        int b = 0;
        bus.emptylist_out_data  = id;
        bus.emptylist_out_valid = 1'b1;
        while (bus.emptylist_out_ready !== 1'b1 && b < 50) begin step(); b++; end
        check("pop_wait", 32'(b < 50), 1);
        step();
        bus.emptylist_out_valid = 1'b0;
        check("ready_after_pop", bus.in_pkt_ready, 1);
    endtask

    task automatic send_flit(input string tag, input logic sop, input logic eop,
                             input logic [5:0] empty, input flit_t d,
                             input logic exp_wr, input logic [PKTBUF_AWIDTH-1:0] exp_addr);
        int b = 0;
        bus.in_pkt_valid = 1'b1;
        bus.in_pkt_sop   = sop;
        bus.in_pkt_eop   = eop;
        bus.in_pkt_empty = empty;
        bus.in_pkt_data  = d;
        while (bus.in_pkt_ready !== 1'b1 && b < 50) begin step(); b++; end
        check({tag, "_accept_wait"}, 32'(b < 50), 1);
        step();
        bus.in_pkt_valid = 1'b0;
        bus.in_pkt_sop   = 1'b0;
        bus.in_pkt_eop   = 1'b0;
        check({tag, "_wr"}, bus.pkt_buffer_write, exp_wr);
        if (exp_wr) begin
            check({tag, "_addr"}, bus.pkt_buffer_address, exp_addr);
            check({tag, "_data"}, bus.pkt_buffer_writedata, d);
        end
    endtask

    task automatic send_pkt(input logic [7:0] id, input int n, input logic [5:0] empty);
        for (int i = 0; i < n; i++)
            send_flit($sformatf("pkt%0d_f%0d", id, i), i == 0, i == n - 1,
                      (i == n - 1) ? empty : 6'd0, mk_data(id, i),
                      i < 32, {id, 5'(i)});
    endtask

    task automatic take_meta(input string tag, input logic [7:0] id, input logic [5:0] flits,
                             input logic [15:0] len, input logic trunc);
        pbuf_meta_t e;
        e.pkt_id = id; e.flits = flits; e.len = len; e.truncated = trunc;
        check({tag, "_mvalid"}, bus.meta_valid, 1);
        check({tag, "_mdata"}, bus.meta_data, e);
        check({tag, "_inrdy_meta"}, bus.in_pkt_ready, 0);
        bus.meta_ready = 1'b1;
        step();
        bus.meta_ready = 1'b0;
        check({tag, "_mvalid_done"}, bus.meta_valid, 0);
        check({tag, "_idle_pop"}, bus.emptylist_out_ready, 1);
    endtask

    initial begin
        int wr_snap;
        pbuf_meta_t e;
        bus.in_pkt_sop = 0; bus.in_pkt_eop = 0; bus.in_pkt_valid = 0;
        bus.in_pkt_data = '0; bus.in_pkt_empty = '0;
        bus.emptylist_out_data = '0; bus.emptylist_out_valid = 1'b1;
        bus.meta_ready = 1'b0;

        // Reset: everything quiet even with an ID on offer.
        step(); step();
        check("rst_wr", bus.pkt_buffer_write, 0);
        check("rst_addr", bus.pkt_buffer_address, 0);
        check("rst_wdata", bus.pkt_buffer_writedata, 0);
        check("rst_mvalid", bus.meta_valid, 0);
        check("rst_inrdy", bus.in_pkt_ready, 0);
        check("rst_elrdy", bus.emptylist_out_ready, 0);
        check("rst_stats", {stats_in_pkt, stats_trunc_pkt, stats_sop_err}, 0);
        bus.emptylist_out_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("post_rst_elrdy", bus.emptylist_out_ready, 1);
        check("post_rst_inrdy", bus.in_pkt_ready, 0);

        // Basic 3-flit packet into slot 5.
        give_id(8'd5);
        send_pkt(8'd5, 3, 6'd10);
        take_meta("p5", 8'd5, 6'd3, 16'd182, 1'b0);
        check("p5_stats_in", stats_in_pkt, 1);

        // Packet waiting on an empty emptylist.
        wr_snap = wr_total;
        bus.in_pkt_valid = 1'b1; bus.in_pkt_sop = 1'b1; bus.in_pkt_data = mk_data(8'd7, 0);
        for (int i = 0; i < 20; i++) begin
            check("starve_inrdy", bus.in_pkt_ready, 0);
            step();
        end
        check("starve_nowr", wr_total - wr_snap, 0);
        give_id(8'd7);
        send_pkt(8'd7, 2, 6'd0);
        take_meta("p7", 8'd7, 6'd2, 16'd128, 1'b0);

        // 40-flit packet truncated to the 32-flit slot.
        give_id(8'd9);
        wr_snap = wr_total;
        send_pkt(8'd9, 40, 6'd0);
        check("p9_write_count", wr_total - wr_snap, 32);
        take_meta("p9", 8'd9, 6'd32, 16'd2560, 1'b1);
        check("p9_stats_trunc", stats_trunc_pkt, 1);
        check("p9_stats_in", stats_in_pkt, 3);

        // Leading non-sop flit is dropped, then a 1-flit packet.
        give_id(8'd11);
        send_flit("nosop", 1'b0, 1'b0, 6'd0, mk_data(8'd11, 99), 1'b0, '0);
        check("nosop_err", stats_sop_err, 1);
        check("nosop_still_write", bus.in_pkt_ready, 1);
        send_flit("p11_f0", 1'b1, 1'b1, 6'd0, mk_data(8'd11, 0), 1'b1, {8'd11, 5'd0});
        take_meta("p11", 8'd11, 6'd1, 16'd64, 1'b0);

        // Meta back-pressure for 10 cycles with a free ID on offer.
        give_id(8'd12);
        send_flit("p12_f0", 1'b1, 1'b1, 6'd4, mk_data(8'd12, 0), 1'b1, {8'd12, 5'd0});
        e.pkt_id = 8'd12; e.flits = 6'd1; e.len = 16'd60; e.truncated = 1'b0;
        bus.emptylist_out_data = 8'd13; bus.emptylist_out_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("stall_mvalid", bus.meta_valid, 1);
            check("stall_mdata", bus.meta_data, e);
            check("stall_inrdy", bus.in_pkt_ready, 0);
            check("stall_elrdy", bus.emptylist_out_ready, 0);
            step();
        end
        bus.meta_ready = 1'b1;
        step();
        bus.meta_ready = 1'b0;
        bus.emptylist_out_valid = 1'b0;
        check("stall_idle", bus.emptylist_out_ready, 1);
        check("stall_mvalid_done", bus.meta_valid, 0);
        check("stall_stats_in", stats_in_pkt, 5);

        // Reset after the 2nd flit of a 4-flit packet.
        give_id(8'd14);
        send_flit("p14_f0", 1'b1, 1'b0, 6'd0, mk_data(8'd14, 0), 1'b1, {8'd14, 5'd0});
        send_flit("p14_f1", 1'b0, 1'b0, 6'd0, mk_data(8'd14, 1), 1'b1, {8'd14, 5'd1});
        wr_snap = wr_total;
        rst = 1'b1;
        bus.in_pkt_valid = 1'b1; bus.in_pkt_data = mk_data(8'd14, 2);
        #1;
        check("mrst_wr", bus.pkt_buffer_write, 0);
        check("mrst_addr", bus.pkt_buffer_address, 0);
        check("mrst_inrdy", bus.in_pkt_ready, 0);
        step(); step();
        check("mrst_mvalid", bus.meta_valid, 0);
        check("mrst_elrdy", bus.emptylist_out_ready, 0);
        check("mrst_stats", {stats_in_pkt, stats_trunc_pkt, stats_sop_err}, 0);
        rst = 1'b0;
        #1;
        check("mrst_idle_pop", bus.emptylist_out_ready, 1);
        check("mrst_idle_inrdy", bus.in_pkt_ready, 0);
        step();
        bus.in_pkt_valid = 1'b0;
        check("mrst_no_meta", bus.meta_valid, 0);
        check("mrst_no_wr", wr_total - wr_snap, 0);
        give_id(8'd15);
        send_pkt(8'd15, 1, 6'd0);
        take_meta("p15", 8'd15, 6'd1, 16'd64, 1'b0);
        check("p15_stats_in", stats_in_pkt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
